reduce3_pipe: RTL

Parametrised, pipelined 3-ary reduction unit built as a tree of NOR3/NAND3-class gate levels with one register per level. It reduces a WIDTH-bit operand to a single bit in one of four modes (NOR, OR, AND, NAND) and carries the mode alongside the data. It sits in the datapath as the shared zero and all-ones detector for branch compare and ALU flag generation. Flow control is a valid/ready handshake with full-rate throughput.

---
 rtl/reduce3_pkg.sv | 43 ++++
 rtl/reduce3_stage.sv | 68 ++++++
 rtl/reduce3_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/reduce3_pkg.sv
// reduce3_pkg: shared modes and elaboration helpers for the 3-ary reduce tree.
// Tag sideband is enabled by defining REDUCE3_TAG_EN.
package reduce3_pkg;

    typedef enum logic [1:0] {
        R3_NOR  = 2'd0,
        R3_OR   = 2'd1,
        R3_AND  = 2'd2,
        R3_NAND = 2'd3
    } r3_mode_e;

    function automatic int r3_levels(input int width);
        int n = 0;
        int p = 1;
        while (p < width) begin
            p = p * 3;
            n++;
        end
        return n;
    endfunction

    function automatic int r3_width_at(input int width, input int level);
        int p = 1;
        for (int k = 0; k < level; k++) p = p * 3;
        return (width + p - 1) / p;
    endfunction

    // Bit offset of a level inside the flattened inter-stage bus.
    function automatic int r3_offset(input int width, input int level);
        int s = 0;
        for (int k = 0; k < level; k++) s = s + r3_width_at(width, k);
        return s;
    endfunction

    function automatic logic r3_identity(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic r3_inverts(input logic [1:0] mode);
        return (mode == R3_NOR) || (mode == R3_NAND);
    endfunction

endpackage

// File: rtl/reduce3_stage.sv
// reduce3_stage: one 3:1 reduce level with its pipeline register and ready term.
// Carries a tag register when REDUCE3_TAG_EN is defined.
module reduce3_stage
    import reduce3_pkg::*;
#(
    parameter int IW   = 3,
    parameter bit LAST = 1'b0
`ifdef REDUCE3_TAG_EN
    , parameter int TAG_W = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_valid,
    input  logic [IW-1:0]         up_data,
    input  logic [1:0]            up_mode,
`ifdef REDUCE3_TAG_EN
    input  logic [TAG_W-1:0]      up_tag,
    output logic [TAG_W-1:0]      tag,
`endif
    input  logic                  dn_ready,
    output logic                  ready,
    output logic                  v,
    output logic [(IW+2)/3-1:0]   data,
    output logic [1:0]            mode
);

    localparam int OW = (IW + 2) / 3;
    localparam int PW = OW * 3;

    logic [PW-1:0] pad;
    logic [OW-1:0] red;
    logic          and_t;
    logic          inv;

    // Short top group is padded with the identity so it cannot change the result.
    always_comb begin
        and_t = r3_identity(up_mode);
        inv   = LAST && r3_inverts(up_mode);
        pad   = {PW{and_t}};
        pad[IW-1:0] = up_data;
        red   = '0;
        for (int g = 0; g < OW; g++) begin
            red[g] = (and_t ? &pad[3*g +: 3] : |pad[3*g +: 3]) ^ inv;
        end
    end

    assign ready = !v || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v    <= 1'b0;
            data <= '0;
            mode <= '0;
`ifdef REDUCE3_TAG_EN
            tag  <= '0;
`endif
        end else if (ready) begin
            v    <= up_valid;
            data <= red;
            mode <= up_mode;
`ifdef REDUCE3_TAG_EN
            tag  <= up_tag;
`endif
        end
    end

endmodule

// File: rtl/reduce3_pipe.sv
// reduce3_pipe: pipelined NOR/OR/AND/NAND reduction, one register per 3:1 level.
// Define REDUCE3_TAG_EN to add the in_tag/out_tag sideband.
module reduce3_pipe
    import reduce3_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [1:0]       in_mode,
`ifdef REDUCE3_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic [1:0]       out_mode
);

    localparam int LEVELS = r3_levels(WIDTH);
    localparam int TOT    = r3_offset(WIDTH, LEVELS + 1);

    if (WIDTH < 2 || WIDTH > 243) begin : g_bad_width
        $error("reduce3_pipe: WIDTH must be 2..243");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("reduce3_pipe: TAG_W must be >= 1");
    end

    // All level vectors packed back to back; level 0 is the operand.
    logic [TOT-1:0]    bus;
    logic [LEVELS:0]   vld;
    logic [LEVELS:0]   rdy;
    logic [1:0]        md [0:LEVELS];
`ifdef REDUCE3_TAG_EN
    logic [TAG_W-1:0]  tg [0:LEVELS];

    assign tg[0]   = in_tag;
    assign out_tag = tg[LEVELS];
`endif

    assign bus[WIDTH-1:0] = in_a;
    assign vld[0]         = in_valid;
    assign md[0]          = in_mode;
    assign rdy[LEVELS]    = out_ready;
    assign in_ready       = rdy[0];

    for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
        localparam int IW  = r3_width_at(WIDTH, i);
        localparam int OW  = r3_width_at(WIDTH, i + 1);
        localparam int OFI = r3_offset(WIDTH, i);
        localparam int OFO = r3_offset(WIDTH, i + 1);

        reduce3_stage #(
            .IW    (IW),
            .LAST  (i == LEVELS - 1)
`ifdef REDUCE3_TAG_EN
            , .TAG_W (TAG_W)
`endif
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld[i]),
            .up_data  (bus[OFI +: IW]),
            .up_mode  (md[i]),
`ifdef REDUCE3_TAG_EN
            .up_tag   (tg[i]),
            .tag      (tg[i+1]),
`endif
            .dn_ready (rdy[i+1]),
            .ready    (rdy[i]),
            .v        (vld[i+1]),
            .data     (bus[OFO +: OW]),
            .mode     (md[i+1])
        );
    end

    assign out_valid = vld[LEVELS];
    assign out_y     = bus[TOT-1];
    assign out_mode  = md[LEVELS];

endmodule
